// File: rtl/id_exe_stage.sv
// id_exe_stage: ID->EXE pipeline register.
// It tracks whether each slot holds a valid instruction. Each clock edge takes
// one mode in priority order: flush, then hold, then bubble, then load.
// It also holds a load-use hazard detector for the instruction now in ID.
// Optional feature macro: ID_EXE_PERF_CNT_EN (adds saturating bubble/flush counters).
module id_exe_stage #(
    parameter int                  DATA_WIDTH     = 32,
    parameter int                  ADDR_WIDTH     = 32,
    parameter int                  RDATA_WIDTH    = 32,
    parameter int                  RADDR_WIDTH    = 5,
    parameter int                  CSR_ADDR_WIDTH = 12,
    parameter int                  STALL_WIDTH    = 6,
    parameter int                  STAGE_IDX      = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_INST     = 32'h00000013,
    parameter int                  CNT_WIDTH      = 32
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic [DATA_WIDTH-1:0]     inst_in,
    input  logic [ADDR_WIDTH-1:0]     inst_address_in,
    input  logic [RDATA_WIDTH-1:0]    op1_in,
    input  logic [RDATA_WIDTH-1:0]    op2_in,
    input  logic [RADDR_WIDTH-1:0]    reg_waddr_in,
    input  logic                      reg_we_in,
    input  logic                      csr_we_in,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_addr_in,
    input  logic                      valid_in,
    input  logic [RADDR_WIDTH-1:0]    id_rs1_in,
    input  logic [RADDR_WIDTH-1:0]    id_rs2_in,
    input  logic [STALL_WIDTH-1:0]    stall_in,
    input  logic                      jump_flush_in,
    output logic [DATA_WIDTH-1:0]     inst_out,
    output logic [ADDR_WIDTH-1:0]     inst_address_out,
    output logic [RDATA_WIDTH-1:0]    op1_out,
    output logic [RDATA_WIDTH-1:0]    op2_out,
    output logic [RADDR_WIDTH-1:0]    reg_waddr_out,
    output logic                      reg_we_out,
    output logic                      csr_we_out,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr_out,
    output logic                      valid_out,
    output logic                      inst_is_load_out,
    output logic [RADDR_WIDTH-1:0]    rd_out,
    output logic                      load_use_hazard_out
`ifdef ID_EXE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      bubble_cnt_out,
    output logic [CNT_WIDTH-1:0]      flush_cnt_out
`endif
);

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    logic w_flush;
    logic w_hold;
    logic w_bubble;

    // Decode the per-edge mode. Flush outranks everything. A stalled stage
    // whose downstream also stalls holds. One whose downstream moves emits a bubble.
    always_comb begin
        w_flush  = jump_flush_in;
        w_hold   = ~jump_flush_in & stall_in[STAGE_IDX] & stall_in[STAGE_IDX+1];
        w_bubble = ~jump_flush_in & stall_in[STAGE_IDX] & ~stall_in[STAGE_IDX+1];
    end

    logic [DATA_WIDTH-1:0]     r_inst;
    logic [ADDR_WIDTH-1:0]     r_inst_address;
    logic [RDATA_WIDTH-1:0]    r_op1;
    logic [RDATA_WIDTH-1:0]    r_op2;
    logic [RADDR_WIDTH-1:0]    r_reg_waddr;
    logic                      r_reg_we;
    logic                      r_csr_we;
    logic [CSR_ADDR_WIDTH-1:0] r_csr_addr;
    logic                      r_valid;
    logic                      r_is_load;
    logic [RADDR_WIDTH-1:0]    r_rd;

    // Pipeline slot. An empty slot (flush, bubble, or invalid load) becomes a NOP
    // with every enable cleared. Only an invalid load updates the PC.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_inst         <= NOP_INST;
            r_inst_address <= '0;
            r_op1          <= '0;
            r_op2          <= '0;
            r_reg_waddr    <= '0;
            r_reg_we       <= 1'b0;
            r_csr_we       <= 1'b0;
            r_csr_addr     <= '0;
            r_valid        <= 1'b0;
            r_is_load      <= 1'b0;
            r_rd           <= '0;
        end else if (w_hold) begin
            r_inst <= r_inst;
        end else if (w_flush || w_bubble || !valid_in) begin
            r_inst      <= NOP_INST;
            r_op1       <= '0;
            r_op2       <= '0;
            r_reg_waddr <= '0;
            r_reg_we    <= 1'b0;
            r_csr_we    <= 1'b0;
            r_csr_addr  <= '0;
            r_valid     <= 1'b0;
            r_is_load   <= 1'b0;
            r_rd        <= '0;
            if (!w_flush && !w_bubble) begin
                r_inst_address <= inst_address_in;
            end
        end else begin
            r_inst         <= inst_in;
            r_inst_address <= inst_address_in;
            r_op1          <= op1_in;
            r_op2          <= op2_in;
            r_reg_waddr    <= reg_waddr_in;
            r_reg_we       <= reg_we_in;
            r_csr_we       <= csr_we_in;
            r_csr_addr     <= csr_addr_in;
            r_valid        <= 1'b1;
            r_is_load      <= (inst_in[6:0] == OPC_LOAD);
            r_rd           <= RADDR_WIDTH'(inst_in[11:7]);
        end
    end

    assign inst_out         = r_inst;
    assign inst_address_out = r_inst_address;
    assign op1_out          = r_op1;
    assign op2_out          = r_op2;
    assign reg_waddr_out    = r_reg_waddr;
    assign reg_we_out       = r_reg_we;
    assign csr_we_out       = r_csr_we;
    assign csr_addr_out     = r_csr_addr;
    assign valid_out        = r_valid;
    assign inst_is_load_out = r_is_load;
    assign rd_out           = r_rd;

    // Load-use hazard: a valid load in EXE whose nonzero rd feeds a source of
    // the instruction now in ID.
    always_comb begin
        load_use_hazard_out = r_valid & r_is_load & (r_rd != '0) &
                              ((r_rd == id_rs1_in) | (r_rd == id_rs2_in));
    end

`ifdef ID_EXE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_bubble_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    // Saturating event counters. Each one stops at all-ones instead of wrapping.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bubble_cnt_out = r_bubble_cnt;
    assign flush_cnt_out  = r_flush_cnt;
`endif

endmodule
